cp0_regs_mmu: RTL and testbench
===============================

// Module: cp0_regs_mmu
// PURPOSE
//  Parametrised CP0 register file for the MIPS pipeline, sitting beside the WB stage.
//  Holds Status/Cause/EPC/BadVAddr/Count/Compare plus full TLB management: Index, Random, Wired, Context, EntryHi/Lo0/Lo1.
//  Adds a Random/Wired replacement counter for TLBWR and Context/BadVPN2 capture on TLB exceptions.
//  TLB depth and Count divider are parameters.
// PARAMETERS
//  TLBNUM   16   TLB entries; power of two, 2..64
//  IDXW     $clog2(TLBNUM)   index width (derived, not overridden)
//  CNT_DIV  2    clk cycles per Count increment (>=1)
// PORTS
//  clk          in   1     clock, single domain
//  resetn       in   1     synchronous active-low reset
//  ext_int      in   6     hardware interrupt lines IP7..IP2
//  wb_valid     in   1     WB instruction valid
//  wb_ex        in   1     WB instruction raises exception
//  wb_bd        in   1     WB instruction in delay slot
//  wb_excode    in   5     exception code
//  wb_pc        in   32    WB PC
//  wb_badvaddr  in   32    faulting virtual address
//  op_mtc0      in   1     MTC0 in WB
//  op_eret      in   1     ERET in WB
//  c0_addr      in   8     {sel[2:0],rd[4:0]} for MTC0/MFC0
//  c0_wdata     in   32    MTC0 data
//  c0_rdata     out  32    MFC0 data, combinational
//  has_int      out  1     pending enabled interrupt
//  epc_out      out  32    current EPC (ERET target)
//  tlbp         in   1     TLBP result valid this cycle
//  tlbp_found   in   1     TLBP hit
//  tlbp_index   in   IDXW  TLBP hit index
//  tlbr         in   1     TLBR result valid this cycle
//  tlbr_entry   in   78    {vpn2[18:0],asid[7:0],g,pfn0[19:0],c0[2:0],d0,v0,pfn1[19:0],c1[2:0],d1,v1}
//  c0_entryhi   out  32    EntryHi
//  c0_entrylo0  out  32    EntryLo0
//  c0_entrylo1  out  32    EntryLo1
//  c0_index     out  32    Index (TLBR/TLBWI target = [IDXW-1:0])
//  c0_random    out  IDXW  TLBWR target index
// BEHAVIOUR
//  - Regs by {sel,rd}: Index 0, Random 1, EntryLo0 2, EntryLo1 3, Context 4, Wired 6,
//    BadVAddr 8, Count 9, EntryHi 10, Compare 11, Status 12, Cause 13, EPC 14. Other addrs read 0.
//  - Reset: all regs 0 except Status.BEV=1, Random=TLBNUM-1. All outputs derive from regs: has_int=0, c0_random=TLBNUM-1.
//  - Write enable: mtc0_we = wb_valid & op_mtc0 & ~wb_ex. Writes land next edge; read-after-write 1 cycle.
//  - Same-cycle priority per field: reset > wb_ex > eret (wb_valid&op_eret&~wb_ex) > tlbr/tlbp > mtc0 > autonomous (Count, Random).
//  - Exception: EXL<=1; ExcCode<=wb_excode. If EXL was 0: EPC<=wb_bd?wb_pc-4:wb_pc, BD<=wb_bd.
//    BadVAddr<=wb_badvaddr on ExcCode 1(Mod),2(TLBL),3(TLBS),4(AdEL),5(AdES).
//    On 1/2/3 also EntryHi.VPN2<=badvaddr[31:13], Context.BadVPN2<=badvaddr[31:13].
//  - ERET: EXL<=0.
//  - Status: IM[15:8], EXL[1], IE[0] writable. Cause: IP[9:8] writable, IP[15:10] sampled each cycle:
//    IP7 = ext_int[5] | TI. Read-only otherwise. has_int = |(IP&IM) & IE & ~EXL.
//  - Timer: Count += 1 every CNT_DIV cycles (phase counter cleared by reset and Count write); wraps at 2^32.
//    TI set when Count==Compare; Compare write clears TI (wins over set).
//  - Index: only [IDXW-1:0] writable. TLBP hit: P<=0, index<=tlbp_index. Miss: P<=1, index unchanged.
//  - TLBR: EntryHi.{VPN2,ASID}, EntryLo0/1 {PFN,C,D,V,G} loaded from tlbr_entry. G copied to both Lo's.
//    Lo[31:26], EntryHi[12:8] read 0.
//  - Wired: [IDXW-1:0] writable. A Wired write also sets Random<=TLBNUM-1.
//  - Random: read-only. Decrements every cycle. When Random==Wired (or Wired>=TLBNUM-1) the next value is TLBNUM-1.
//    Never leaves [Wired, TLBNUM-1].
//  - Context: PTEBase[31:23] writable, BadVPN2[22:4] hw-only, [3:0]=0.
//  - EntryHi: VPN2[31:13], ASID[7:0] writable.
// STRUCTURE
//  - Shared header mycpu.h: CR_* address constants, EX_* exception codes.
//  - Sub-module cp0_timer: Count, Compare, divider, TI; exports count/compare/ti.
//  - Random/Wired counter and all other regs stay inline.
// TESTING
//  - Reset with TLBNUM=16: Status=0x0040_0000, Random=15, Index=0, has_int=0.
//  - Random/Wired: mtc0 Wired=4; sample 13 cycles -> Random 15,14..4,15, wraps. Wired=15 -> Random stuck at 15.
//  - Delay-slot TLBL: wb_ex, excode=2, bd=1, pc=0xBFC0_0104, badvaddr=0x1234_5678 ->
//    EPC=0xBFC0_0100, Cause.BD=1, ExcCode=2, BadVAddr=0x1234_5678, EntryHi.VPN2=0x091A2, EXL=1.
//    Second exception with EXL=1 leaves EPC unchanged.
//  - TLBP miss then hit idx 9: Index=0x8000_0000 then 0x0000_0009. tlbr same cycle as mtc0 EntryHi -> tlbr data wins.
//  - Timer, CNT_DIV=2: Compare=5, IM7=1, IE=1 -> TI set ~10 cycles later, has_int=1. Compare write clears it.
//  - ERET with wb_ex same cycle -> EXL stays 1. mtc0 with wb_ex -> no write.

Source files
------------

// File: rtl/cp0_regs_mmu_pkg.sv
// CP0 register map, exception codes and TLB entry layouts
// shared by the CP0 register file and its timer.
package cp0_regs_mmu_pkg;

  localparam logic [7:0] CR_INDEX    = 8'd0;
  localparam logic [7:0] CR_RANDOM   = 8'd1;
  localparam logic [7:0] CR_ENTRYLO0 = 8'd2;
  localparam logic [7:0] CR_ENTRYLO1 = 8'd3;
  localparam logic [7:0] CR_CONTEXT  = 8'd4;
  localparam logic [7:0] CR_WIRED    = 8'd6;
  localparam logic [7:0] CR_BADVADDR = 8'd8;
  localparam logic [7:0] CR_COUNT    = 8'd9;
  localparam logic [7:0] CR_ENTRYHI  = 8'd10;
  localparam logic [7:0] CR_COMPARE  = 8'd11;
  localparam logic [7:0] CR_STATUS   = 8'd12;
  localparam logic [7:0] CR_CAUSE    = 8'd13;
  localparam logic [7:0] CR_EPC      = 8'd14;

  localparam logic [4:0] EX_INT  = 5'd0;
  localparam logic [4:0] EX_MOD  = 5'd1;
  localparam logic [4:0] EX_TLBL = 5'd2;
  localparam logic [4:0] EX_TLBS = 5'd3;
  localparam logic [4:0] EX_ADEL = 5'd4;
  localparam logic [4:0] EX_ADES = 5'd5;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
    logic        g;
  } lo_t;

  function automatic logic is_tlb_ex(input logic [4:0] c);
    return (c == EX_MOD) || (c == EX_TLBL) || (c == EX_TLBS);
  endfunction

  function automatic logic is_addr_ex(input logic [4:0] c);
    return is_tlb_ex(c) || (c == EX_ADEL) || (c == EX_ADES);
  endfunction

endpackage

// File: rtl/cp0_regs_mmu_if.sv
// WB-side bus between the pipeline / TLB and the CP0 register file.
// The master modport is the pipeline, the slave modport is CP0.
interface cp0_regs_mmu_if #(
  parameter int TLBNUM = 16
);
  localparam int IDXW = $clog2(TLBNUM);

  logic [5:0]      ext_int;
  logic            wb_valid;
  logic            wb_ex;
  logic            wb_bd;
  logic [4:0]      wb_excode;
  logic [31:0]     wb_pc;
  logic [31:0]     wb_badvaddr;
  logic            op_mtc0;
  logic            op_eret;
  logic [7:0]      c0_addr;
  logic [31:0]     c0_wdata;
  logic [31:0]     c0_rdata;
  logic            has_int;
  logic [31:0]     epc_out;
  logic            tlbp;
  logic            tlbp_found;
  logic [IDXW-1:0] tlbp_index;
  logic            tlbr;
  logic [77:0]     tlbr_entry;
  logic [31:0]     c0_entryhi;
  logic [31:0]     c0_entrylo0;
  logic [31:0]     c0_entrylo1;
  logic [31:0]     c0_index;
  logic [IDXW-1:0] c0_random;

  modport master (
    output ext_int, wb_valid, wb_ex, wb_bd, wb_excode,
    output wb_pc, wb_badvaddr, op_mtc0, op_eret,
    output c0_addr, c0_wdata,
    output tlbp, tlbp_found, tlbp_index, tlbr, tlbr_entry,
    input  c0_rdata, has_int, epc_out,
    input  c0_entryhi, c0_entrylo0, c0_entrylo1,
    input  c0_index, c0_random
  );

  modport slave (
    input  ext_int, wb_valid, wb_ex, wb_bd, wb_excode,
    input  wb_pc, wb_badvaddr, op_mtc0, op_eret,
    input  c0_addr, c0_wdata,
    input  tlbp, tlbp_found, tlbp_index, tlbr, tlbr_entry,
    output c0_rdata, has_int, epc_out,
    output c0_entryhi, c0_entrylo0, c0_entrylo1,
    output c0_index, c0_random
  );

endinterface

// File: rtl/cp0_regs_mmu_timer.sv
// CP0 Count/Compare timer: Count advances once every CNT_DIV clocks,
// TI latches on Count==Compare until Compare is rewritten.
module cp0_regs_mmu_timer #(
  parameter int CNT_DIV = 2
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_cnt_we,
  input  logic        i_cmp_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);

  localparam int PW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CNT_DIV - 1);

  logic [PW-1:0] r_phase;
  logic [31:0]   r_count;
  logic [31:0]   r_compare;
  logic          r_ti;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_phase   <= '0;
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      if (i_cnt_we) begin
        r_count <= i_wdata;
        r_phase <= '0;
      end else if (r_phase == LAST) begin
        r_count <= r_count + 32'd1;
        r_phase <= '0;
      end else begin
        r_phase <= r_phase + 1'b1;
      end
      if (i_cmp_we) r_compare <= i_wdata;
      // a Compare write acknowledges the interrupt, even on a match
      if (i_cmp_we) r_ti <= 1'b0;
      else if (r_count == r_compare) r_ti <= 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_regs_mmu.sv
// CP0 register file beside WB: exception state, interrupts,
// timer and TLB management registers with Random/Wired replacement.
module cp0_regs_mmu
  import cp0_regs_mmu_pkg::*;
#(
  parameter int TLBNUM  = 16,
  parameter int CNT_DIV = 2
) (
  input logic        clk,
  input logic        resetn,
  cp0_regs_mmu_if.slave cp0
);

  localparam int IDXW = $clog2(TLBNUM);
  localparam logic [IDXW-1:0] RMAX = IDXW'(TLBNUM - 1);

  tlb_entry_t w_e;
  logic w_ex, w_eret, w_we;
  logic [31:0] w_count, w_compare, w_rdata;
  logic w_ti;

  logic            r_idx_p;
  logic [IDXW-1:0] r_idx, r_random, r_wired;
  lo_t             r_lo0, r_lo1;
  logic [8:0]      r_ptebase;
  logic [18:0]     r_badvpn2, r_vpn2;
  logic [7:0]      r_asid, r_im;
  logic [31:0]     r_badvaddr, r_epc;
  logic            r_exl, r_ie, r_bd;
  logic [5:0]      r_ip_hw;
  logic [1:0]      r_ip_sw;
  logic [4:0]      r_excode;

  assign w_e    = cp0.tlbr_entry;
  assign w_ex   = cp0.wb_ex;
  assign w_eret = cp0.wb_valid & cp0.op_eret & ~cp0.wb_ex;
  assign w_we   = cp0.wb_valid & cp0.op_mtc0 & ~cp0.wb_ex;

  function automatic logic we_at(input logic [7:0] a);
    return w_we && (cp0.c0_addr == a);
  endfunction

  cp0_regs_mmu_timer #(.CNT_DIV(CNT_DIV)) u_timer (
    .i_clk     (clk),
    .i_resetn  (resetn),
    .i_cnt_we  (we_at(CR_COUNT)),
    .i_cmp_we  (we_at(CR_COMPARE)),
    .i_wdata   (cp0.c0_wdata),
    .o_count   (w_count),
    .o_compare (w_compare),
    .o_ti      (w_ti)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_idx_p    <= 1'b0;
      r_idx      <= '0;
      r_random   <= RMAX;
      r_wired    <= '0;
      r_lo0      <= '0;
      r_lo1      <= '0;
      r_ptebase  <= '0;
      r_badvpn2  <= '0;
      r_vpn2     <= '0;
      r_asid     <= '0;
      r_im       <= '0;
      r_badvaddr <= '0;
      r_epc      <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip_hw    <= '0;
      r_ip_sw    <= '0;
      r_excode   <= '0;
    end else begin
      if (cp0.tlbp) begin
        r_idx_p <= ~cp0.tlbp_found;
        if (cp0.tlbp_found) r_idx <= cp0.tlbp_index;
      end else if (we_at(CR_INDEX)) begin
        r_idx <= cp0.c0_wdata[IDXW-1:0];
      end
      // Random walks down to Wired then reloads from the top
      if (we_at(CR_WIRED)) begin
        r_wired  <= cp0.c0_wdata[IDXW-1:0];
        r_random <= RMAX;
      end else if (r_random <= r_wired || r_wired >= RMAX) begin
        r_random <= RMAX;
      end else begin
        r_random <= r_random - 1'b1;
      end
      if (cp0.tlbr) begin
        r_lo0 <= {w_e.pfn0, w_e.c0, w_e.d0, w_e.v0, w_e.g};
        r_lo1 <= {w_e.pfn1, w_e.c1, w_e.d1, w_e.v1, w_e.g};
      end else begin
        if (we_at(CR_ENTRYLO0)) r_lo0 <= cp0.c0_wdata[25:0];
        if (we_at(CR_ENTRYLO1)) r_lo1 <= cp0.c0_wdata[25:0];
      end
      if (we_at(CR_CONTEXT)) r_ptebase <= cp0.c0_wdata[31:23];
      if (w_ex && is_tlb_ex(cp0.wb_excode))
        r_badvpn2 <= cp0.wb_badvaddr[31:13];
      if (w_ex && is_addr_ex(cp0.wb_excode))
        r_badvaddr <= cp0.wb_badvaddr;
      if (w_ex && is_tlb_ex(cp0.wb_excode))
        r_vpn2 <= cp0.wb_badvaddr[31:13];
      else if (cp0.tlbr) r_vpn2 <= w_e.vpn2;
      else if (we_at(CR_ENTRYHI)) r_vpn2 <= cp0.c0_wdata[31:13];
      if (cp0.tlbr) r_asid <= w_e.asid;
      else if (we_at(CR_ENTRYHI)) r_asid <= cp0.c0_wdata[7:0];
      if (we_at(CR_STATUS)) begin
        r_im <= cp0.c0_wdata[15:8];
        r_ie <= cp0.c0_wdata[0];
      end
      if (w_ex) r_exl <= 1'b1;
      else if (w_eret) r_exl <= 1'b0;
      else if (we_at(CR_STATUS)) r_exl <= cp0.c0_wdata[1];
      r_ip_hw <= {cp0.ext_int[5] | w_ti, cp0.ext_int[4:0]};
      if (we_at(CR_CAUSE)) r_ip_sw <= cp0.c0_wdata[9:8];
      if (w_ex) begin
        r_excode <= cp0.wb_excode;
        if (!r_exl) begin
          r_bd  <= cp0.wb_bd;
          r_epc <= cp0.wb_bd ? cp0.wb_pc - 32'd4 : cp0.wb_pc;
        end
      end else if (we_at(CR_EPC)) begin
        r_epc <= cp0.c0_wdata;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    unique case (cp0.c0_addr)
      CR_INDEX:    w_rdata = cp0.c0_index;
      CR_RANDOM:   w_rdata = 32'(r_random);
      CR_ENTRYLO0: w_rdata = cp0.c0_entrylo0;
      CR_ENTRYLO1: w_rdata = cp0.c0_entrylo1;
      CR_CONTEXT:  w_rdata = {r_ptebase, r_badvpn2, 4'b0};
      CR_WIRED:    w_rdata = 32'(r_wired);
      CR_BADVADDR: w_rdata = r_badvaddr;
      CR_COUNT:    w_rdata = w_count;
      CR_ENTRYHI:  w_rdata = cp0.c0_entryhi;
      CR_COMPARE:  w_rdata = w_compare;
      CR_STATUS:   w_rdata = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
      CR_CAUSE:    w_rdata = {r_bd, w_ti, 14'b0, r_ip_hw, r_ip_sw,
                              1'b0, r_excode, 2'b0};
      CR_EPC:      w_rdata = r_epc;
      default:     w_rdata = '0;
    endcase
  end

  assign cp0.c0_rdata    = w_rdata;
  assign cp0.has_int     = (|({r_ip_hw, r_ip_sw} & r_im)) & r_ie & ~r_exl;
  assign cp0.epc_out     = r_epc;
  assign cp0.c0_entryhi  = {r_vpn2, 5'b0, r_asid};
  assign cp0.c0_entrylo0 = {6'b0, r_lo0};
  assign cp0.c0_entrylo1 = {6'b0, r_lo1};
  assign cp0.c0_index    = {r_idx_p, {(31 - IDXW){1'b0}}, r_idx};
  assign cp0.c0_random   = r_random;

endmodule

// File: tb/tb_cp0_regs_mmu.sv
// Directed plus randomized checks of cp0_regs_mmu against a
// register-map model kept in the bench.
module tb_cp0_regs_mmu;

  localparam int TLBNUM = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cp0_regs_mmu_if #(.TLBNUM(TLBNUM)) bus ();

  cp0_regs_mmu #(.TLBNUM(TLBNUM), .CNT_DIV(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .cp0    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  addrs [8] = '{8'd0, 8'd2, 8'd3, 8'd4, 8'd10, 8'd14, 8'd5, 8'h2A};
  logic [31:0] shadow [8];
  logic [31:0] v, v2, d, expv;
  int          ia, ja, w, n, cyc;
  logic [18:0] f_vpn2;
  logic [7:0]  f_asid;
  logic        f_g, f_d0, f_v0, f_d1, f_v1;
  logic [19:0] f_pfn0, f_pfn1;
  logic [2:0]  f_c0, f_c1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ext_int     = '0;
    bus.wb_valid    = 1'b0;
    bus.wb_ex       = 1'b0;
    bus.wb_bd       = 1'b0;
    bus.wb_excode   = '0;
    bus.wb_pc       = '0;
    bus.wb_badvaddr = '0;
    bus.op_mtc0     = 1'b0;
    bus.op_eret     = 1'b0;
    bus.c0_addr     = '0;
    bus.c0_wdata    = '0;
    bus.tlbp        = 1'b0;
    bus.tlbp_found  = 1'b0;
    bus.tlbp_index  = '0;
    bus.tlbr        = 1'b0;
    bus.tlbr_entry  = '0;
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] dd);
    bus.wb_valid = 1'b1;
    bus.op_mtc0  = 1'b1;
    bus.c0_addr  = a;
    bus.c0_wdata = dd;
    tick();
    bus.wb_valid = 1'b0;
    bus.op_mtc0  = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] q);
    bus.c0_addr = a;
    #1;
    q = bus.c0_rdata;
  endtask

  task automatic exc(input logic [4:0] code, input logic bd,
                     input logic [31:0] pc, input logic [31:0] bva);
    bus.wb_valid    = 1'b1;
    bus.wb_ex       = 1'b1;
    bus.wb_excode   = code;
    bus.wb_bd       = bd;
    bus.wb_pc       = pc;
    bus.wb_badvaddr = bva;
    tick();
    idle();
  endtask

  function automatic logic [31:0] wmask(input logic [7:0] a);
    case (a)
      8'd0:       return 32'h0000_000F;
      8'd2, 8'd3: return 32'h03FF_FFFF;
      8'd4:       return 32'hFF80_0000;
      8'd10:      return 32'hFFFF_E0FF;
      8'd14:      return 32'hFFFF_FFFF;
      default:    return 32'h0;
    endcase
  endfunction

  // Random value k cycles after a Wired write of ww
  function automatic int rand_after(input int ww, input int k);
    if (ww >= TLBNUM - 1) return TLBNUM - 1;
    return (TLBNUM - 1) - (k % (TLBNUM - ww));
  endfunction

  initial begin
    idle();
    resetn = 1'b0;
    repeat (3) tick();
    rd(8'd12, v); chk("rst_status", v, 32'h0040_0000);
    rd(8'd1, v);  chk("rst_random_rd", v, 32'd15);
    chk("rst_random", 32'(bus.c0_random), 32'd15);
    chk("rst_index", bus.c0_index, 32'h0);
    chk("rst_has_int", 32'(bus.has_int), 32'd0);
    chk("rst_epc", bus.epc_out, 32'h0);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) shadow[i] = '0;
    for (int it = 0; it < 24; it++) begin
      ia = $urandom_range(0, 7);
      d  = $urandom;
      mtc0(addrs[ia], d);
      shadow[ia] = d & wmask(addrs[ia]);
      ja = $urandom_range(0, 7);
      rd(addrs[ja], v);
      chk($sformatf("rw_%0d", addrs[ja]), v, shadow[ja]);
    end
    chk("rw_entryhi_out", bus.c0_entryhi, shadow[4]);
    chk("rw_lo0_out", bus.c0_entrylo0, shadow[1]);
    chk("rw_lo1_out", bus.c0_entrylo1, shadow[2]);

    mtc0(8'd6, 32'd4);
    for (int k = 0; k < 13; k++) begin
      chk($sformatf("wired4_%0d", k), 32'(bus.c0_random),
          32'(15 - (k % 12)));
      tick();
    end
    mtc0(8'd6, 32'd15);
    rd(8'd6, v); chk("wired15_rd", v, 32'd15);
    for (int k = 0; k < 4; k++) begin
      chk("wired15_stuck", 32'(bus.c0_random), 32'd15);
      tick();
    end
    for (int it = 0; it < 8; it++) begin
      w = $urandom_range(0, 15);
      mtc0(8'd6, 32'(w));
      n = $urandom_range(0, 40);
      repeat (n) tick();
      expv = 32'(rand_after(w, n));
      chk($sformatf("rand_w%0d_n%0d", w, n), 32'(bus.c0_random), expv);
      rd(8'd1, v); chk("rand_rd", v, expv);
    end
    mtc0(8'd6, 32'd0);

    exc(5'd2, 1'b1, 32'hBFC0_0104, 32'h1234_5678);
    rd(8'd14, v); chk("ex_epc", v, 32'hBFC0_0100);
    rd(8'd13, v); chk("ex_cause", v & 32'h8000_007C, 32'h8000_0008);
    rd(8'd8, v);  chk("ex_badvaddr", v, 32'h1234_5678);
    chk("ex_vpn2", 32'(bus.c0_entryhi[31:13]), 32'h091A2);
    rd(8'd12, v); chk("ex_exl", v, 32'h0040_0002);
    rd(8'd4, v);  chk("ex_ctx_vpn", 32'(v[22:4]), 32'h091A2);
    exc(5'd4, 1'b0, 32'h8000_0010, 32'h0000_0ABC);
    chk("ex2_epc", bus.epc_out, 32'hBFC0_0100);
    rd(8'd13, v); chk("ex2_cause", v & 32'h8000_007C, 32'h8000_0010);
    rd(8'd8, v);  chk("ex2_badvaddr", v, 32'h0000_0ABC);
    chk("ex2_vpn2", 32'(bus.c0_entryhi[31:13]), 32'h091A2);

    bus.wb_valid = 1'b1; bus.op_mtc0 = 1'b1; bus.wb_ex = 1'b1;
    bus.c0_addr = 8'd14; bus.c0_wdata = 32'h1111_1111;
    tick(); idle();
    chk("mtc0_ex_blocked", bus.epc_out, 32'hBFC0_0100);
    bus.wb_valid = 1'b1; bus.op_eret = 1'b1; bus.wb_ex = 1'b1;
    tick(); idle();
    rd(8'd12, v); chk("eret_ex_exl", v, 32'h0040_0002);
    bus.wb_valid = 1'b1; bus.op_eret = 1'b1;
    tick(); idle();
    rd(8'd12, v); chk("eret_exl", v, 32'h0040_0000);

    mtc0(8'd0, 32'd0);
    bus.tlbp = 1'b1; bus.tlbp_found = 1'b0; bus.tlbp_index = 4'd3;
    tick();
    chk("tlbp_miss", bus.c0_index, 32'h8000_0000);
    bus.tlbp_found = 1'b1; bus.tlbp_index = 4'd9;
    tick(); idle();
    chk("tlbp_hit", bus.c0_index, 32'h0000_0009);

    {f_vpn2, f_asid, f_g} = 28'($urandom);
    {f_pfn0, f_c0, f_d0, f_v0} = 25'($urandom);
    {f_pfn1, f_c1, f_d1, f_v1} = 25'($urandom);
    bus.tlbr = 1'b1;
    bus.tlbr_entry = {f_vpn2, f_asid, f_g, f_pfn0, f_c0, f_d0, f_v0,
                      f_pfn1, f_c1, f_d1, f_v1};
    bus.wb_valid = 1'b1; bus.op_mtc0 = 1'b1;
    bus.c0_addr = 8'd10; bus.c0_wdata = ~{f_vpn2, 5'b0, f_asid};
    tick(); idle();
    chk("tlbr_hi", bus.c0_entryhi, {f_vpn2, 5'b0, f_asid});
    chk("tlbr_lo0", bus.c0_entrylo0, {6'b0, f_pfn0, f_c0, f_d0, f_v0, f_g});
    chk("tlbr_lo1", bus.c0_entrylo1, {6'b0, f_pfn1, f_c1, f_d1, f_v1, f_g});

    mtc0(8'd9, 32'd0);
    mtc0(8'd11, 32'd5);
    mtc0(8'd12, 32'h0000_8001);
    rd(8'd12, v); chk("tmr_status", v, 32'h0040_8001);
    chk("tmr_no_int", 32'(bus.has_int), 32'd0);
    cyc = 0;
    while (!bus.has_int && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("tmr_has_int", 32'(bus.has_int), 32'd1);
    chk("tmr_latency", 32'(cyc >= 8 && cyc <= 12), 32'd1);
    rd(8'd13, v); chk("tmr_cause", v & 32'h4000_8000, 32'h4000_8000);
    mtc0(8'd11, 32'd1000);
    rd(8'd13, v); chk("tmr_ti_clr", 32'(v[30]), 32'd0);
    tick();
    chk("tmr_int_clr", 32'(bus.has_int), 32'd0);

    rd(8'd9, v);
    repeat (10) tick();
    rd(8'd9, v2);
    chk("count_rate", v2 - v, 32'd5);

    bus.ext_int = 6'b000001;
    mtc0(8'd12, 32'h0000_0401);
    chk("ext_int", 32'(bus.has_int), 32'd1);
    rd(8'd13, v); chk("ext_ip2", v & 32'h0000_0400, 32'h0000_0400);
    bus.ext_int = 6'b0;
    tick(); tick();
    chk("ext_int_clr", 32'(bus.has_int), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
